muldiv_seq: RTL

//  Iterative multiply/divide sequencer for the EX stage (RV32M ops).

---
 rtl/muldiv_seq_if.sv | 24 ++
 rtl/muldiv_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the EX stage and the iterative mul/div sequencer.
// master = EX stage (issues ops, watches busy/done), slave = muldiv_seq.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, a, b, flush,
      input  busy, done, result
   );

   modport slave (
      input  start, op, a, b, flush,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 iterative RV32M multiply/divide sequencer.
// IDLE -> PREP -> CALC (XLEN iterations) -> FIX; done pulses during FIX with the result.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// the iteration loop and finish in cycle 3 instead of cycle XLEN+2.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   muldiv_seq_if.slave bus
);
   localparam int              CW       = $clog2(XLEN);
   localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] ONE      = XLEN'(1);
   localparam logic [2*XLEN-1:0] ONE2   = (2*XLEN)'(1);
   localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q;
   logic [XLEN-1:0] a_q, b_q;        // raw operands as issued
   logic [XLEN-1:0] mcand_q;         // multiplicand (mul) or divisor (div) magnitude
   logic [XLEN-1:0] acc_q;           // product high half / partial remainder
   logic [XLEN-1:0] lo_q;            // multiplier -> product low half / dividend -> quotient
   logic            sa_q, sb_q;      // operand signs taken in PREP
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] result_q;

   // Operand classification
   logic            is_div, signed_a, signed_b, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            div0, ovf, special;

   always_comb begin
      is_div   = op_q[2];
      signed_a = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
      signed_b = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);
      a_neg    = signed_a & a_q[XLEN-1];
      b_neg    = signed_b & b_q[XLEN-1];
      // MIN negates to itself, which read unsigned is exactly 2^(XLEN-1)
      a_mag    = a_neg ? (~a_q + ONE) : a_q;
      b_mag    = b_neg ? (~b_q + ONE) : b_q;
      div0     = (b_q == '0);
      ovf      = signed_b && (a_q == MIN_VAL) && (b_q == '1);
      special  = is_div & (div0 | ovf);
   end

   // One iteration step of the shift-add multiplier and restoring divider
   logic [XLEN:0] mul_sum, div_shift, div_diff;
   logic          div_keep;

   always_comb begin
      mul_sum   = {1'b0, acc_q} + {1'b0, mcand_q};
      div_shift = {acc_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, mcand_q};
      // partial remainder stays below the divisor, so XLEN+1 bits hold the sign of the trial
      div_keep  = ~div_diff[XLEN];
   end

   // Sign fix-up and result selection, meaningful while in FIX
   logic [2*XLEN-1:0] prod, prod_fix;
   logic [XLEN-1:0]   quot_fix, rem_fix, fix_val;

   always_comb begin
      prod     = {acc_q, lo_q};
      prod_fix = (sa_q ^ sb_q) ? (~prod + ONE2) : prod;
      quot_fix = (sa_q ^ sb_q) ? (~lo_q + ONE) : lo_q;
      rem_fix  = sa_q ? (~acc_q + ONE) : acc_q;
      fix_val  = '0;
      case (op_q)
         3'd0:                fix_val = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3:    fix_val = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:          fix_val = div0 ? '1 : (ovf ? MIN_VAL : quot_fix);
         default:             fix_val = div0 ? a_q : (ovf ? '0 : rem_fix);
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; flush aborts from any state and beats a simultaneous start
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.start) state_d = PREP;
            PREP:    state_d = CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath: operand capture, magnitude prep, iteration, result write-back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  op_q <= bus.op;
                  a_q  <= bus.a;
                  b_q  <= bus.b;
               end
            end
            PREP: begin
               sa_q  <= a_neg;
               sb_q  <= b_neg;
               acc_q <= '0;
               if (is_div) begin
                  mcand_q <= b_mag;
                  lo_q    <= a_mag;
               end else begin
                  mcand_q <= a_mag;
                  lo_q    <= b_mag;
               end
`ifdef MULDIV_EARLY_OUT_EN
               // Special divides need no iterations: a single CALC pass with the counter
               // preloaded to its last value lets FIX fire in cycle 3.
               cnt_q <= special ? CNT_LAST : '0;
`else
               cnt_q <= '0;
`endif
            end
            CALC: begin
               cnt_q <= cnt_q + 1'b1;
               if (is_div) begin
                  acc_q <= div_keep ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                  lo_q  <= {lo_q[XLEN-2:0], div_keep};
               end else if (lo_q[0]) begin
                  {acc_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
               end else begin
                  {acc_q, lo_q} <= {1'b0, acc_q, lo_q[XLEN-1:1]};
               end
            end
            default: begin
               if (!bus.flush) result_q <= fix_val;
            end
         endcase
      end
   end

   // Outputs: result is presented combinationally in the done cycle and held afterwards
   always_comb begin
      bus.busy   = (state_q != IDLE);
      bus.done   = (state_q == FIX) && !bus.flush;
      bus.result = bus.done ? fix_val : result_q;
   end
endmodule
